// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchroniser, glitch filter, post-reset hold-off, step/dir/err generation.
// x1 decoding by default; define QDEC_X4_EN for x4 decoding (every legal transition steps).
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic enable,
  input  logic err_clr,
  output logic step,
  output logic dir,
  output logic err,
  output logic err_sticky,
  output logic ready
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam int HO = SYNC_STAGES + FILT_LEN;
  localparam int HW = $clog2(HO + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             syn;
  logic [1:0]             filt_q, filt_d;
  logic [CW-1:0]          cnt_q [2];
  logic [CW-1:0]          cnt_d [2];
  logic [HW-1:0]          ho_q, ho_d;
  logic                   holdoff;
  logic                   ready_q, ready_d;
  logic [1:0]             prev_q;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   dir_q, dir_d;
  logic                   sticky_q, sticky_d;
  logic                   fwd_mv, rev_mv, illegal, step_ev;

  // Gray-code successor in the forward direction, state packed as {A,B}
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
    end
  end

  assign syn     = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign holdoff = (ho_q != HW'(HO));

  always_comb begin
    ho_d    = holdoff ? ho_q + HW'(1) : ho_q;
    ready_d = ready_q | ~holdoff;
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (holdoff) begin
        filt_d[i] = syn[i];
      end else if (syn[i] != filt_q[i]) begin
        // the FILT_LEN-th consecutive differing sample commits the change
        if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_d[i] = syn[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    fwd_mv   = 1'b0;
    rev_mv   = 1'b0;
    illegal  = 1'b0;
    step_ev  = 1'b0;
    step_d   = 1'b0;
    err_d    = 1'b0;
    dir_d    = dir_q;
    if (ready_q && (filt_q != prev_q)) begin
      if (filt_q == fwd_next(prev_q)) begin
        fwd_mv = 1'b1;
      end else if (prev_q == fwd_next(filt_q)) begin
        rev_mv = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end
`ifdef QDEC_X4_EN
    step_ev = fwd_mv | rev_mv;
`else
    step_ev = (fwd_mv && prev_q == 2'b00) || (rev_mv && prev_q == 2'b10);
`endif
    // direction keeps tracking motion even while pulses are suppressed
    if (step_ev) begin
      dir_d  = fwd_mv;
      step_d = enable;
    end
    if (illegal) begin
      err_d = enable;
    end
    sticky_d = (sticky_q & ~err_clr) | err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      ho_q     <= '0;
      ready_q  <= 1'b0;
      prev_q   <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      ho_q     <= ho_d;
      ready_q  <= ready_d;
      prev_q   <= filt_q;
      step_q   <= step_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      sticky_q <= sticky_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder in its default x1 build with SYNC_STAGES=2, FILT_LEN=4.
module tb_quad_decoder;

  localparam int LAT = 7;

  logic clk = 1'b0;
  logic rst, a_in, b_in, enable, err_clr;
  logic step, dir, err, err_sticky, ready;

  quad_decoder #(.SYNC_STAGES(2), .FILT_LEN(4)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .enable(enable),
    .err_clr(err_clr), .step(step), .dir(dir), .err(err),
    .err_sticky(err_sticky), .ready(ready)
  );

  always #5 clk = ~clk;

  // kind: 0 = no pulse, 1 = step, 2 = err; dir_after < 0 means not checked
  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   kind;
    logic dir;
    int   dir_after;
  } vec_t;

  typedef struct {
    int   due;
    int   kind;
    logic dir;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse observed, expected kind %0d at cycle %0d", sb[0].kind, sb[0].due);
      void'(sb.pop_front());
    end
    if (step && err) begin
      checks++;
      errors++;
      $display("FAIL step_err_overlap: step=1 err=1, expected at most one (cycle %0d)", cyc);
    end
    if (step || err) begin
      checks++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        errors++;
        $display("FAIL unexpected_pulse: step=%0b err=%0b at cycle %0d, expected none (next due %0d)",
                 step, err, cyc, (sb.size() > 0) ? sb[0].due : -1);
      end else begin
        e = sb.pop_front();
        if ((e.kind == 1 && !(step && dir == e.dir)) || (e.kind == 2 && !err)) begin
          errors++;
          $display("FAIL pulse_kind: step=%0b err=%0b dir=%0b, expected kind %0d dir %0b (cycle %0d)",
                   step, err, dir, e.kind, e.dir, cyc);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic apply(input vec_t v);
    a_in = v.a;
    b_in = v.b;
    if (v.kind != 0) sb.push_back('{due: cyc + LAT, kind: v.kind, dir: v.dir});
    repeat (v.hold) tick();
    if (v.dir_after >= 0) check("dir_after", dir, logic'(v.dir_after));
  endtask

  task automatic release_and_check_ready();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ready_holdoff", ready, 1'b0);
    end
    tick();
    check("ready_rise", ready, 1'b1);
  endtask

  vec_t tbl  [15];
  vec_t tbl2 [6];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 20, 0, 1'b0, -1};
    tbl[1]  = '{1'b0, 1'b0, 20, 0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 20, 1, 1'b1, 1};
    tbl[3]  = '{1'b1, 1'b1, 20, 0, 1'b0, -1};
    tbl[4]  = '{1'b0, 1'b1, 20, 0, 1'b0, -1};
    tbl[5]  = '{1'b0, 1'b0, 20, 0, 1'b0, 1};
    tbl[6]  = '{1'b0, 1'b1, 20, 0, 1'b0, -1};
    tbl[7]  = '{1'b1, 1'b1, 20, 0, 1'b0, -1};
    tbl[8]  = '{1'b1, 1'b0, 20, 0, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b0, 20, 1, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b0, 3,  0, 1'b0, -1};
    tbl[11] = '{1'b0, 1'b0, 20, 0, 1'b0, 0};
    tbl[12] = '{1'b1, 1'b0, 4,  1, 1'b1, -1};
    tbl[13] = '{1'b0, 1'b0, 20, 1, 1'b0, 0};
    tbl[14] = '{1'b1, 1'b1, 20, 2, 1'b0, 0};

    tbl2[0] = '{1'b0, 1'b1, 20, 0, 1'b0, -1};
    tbl2[1] = '{1'b0, 1'b0, 20, 0, 1'b0, 0};
    tbl2[2] = '{1'b1, 1'b0, 20, 0, 1'b0, 1};
    tbl2[3] = '{1'b1, 1'b1, 20, 0, 1'b0, -1};
    tbl2[4] = '{1'b0, 1'b1, 20, 0, 1'b0, -1};
    tbl2[5] = '{1'b0, 1'b0, 20, 0, 1'b0, 1};

    rst = 1'b1; a_in = 1'b1; b_in = 1'b1; enable = 1'b1; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_step", step, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sticky", err_sticky, 1'b0);
    check("rst_ready", ready, 1'b0);
    release_and_check_ready();
    repeat (10) tick();

    for (int i = 0; i < 15; i++) apply(tbl[i]);
    check("sticky_set", err_sticky, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sticky_clr", err_sticky, 1'b0);

    // illegal 11->00 with err_clr coinciding with the err pulse
    a_in = 1'b0; b_in = 1'b0;
    sb.push_back('{due: cyc + LAT, kind: 2, dir: 1'b0});
    repeat (LAT - 1) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sticky_set_wins", err_sticky, 1'b1);
    repeat (13) tick();
    check("sticky_hold", err_sticky, 1'b1);

    // reset asserted while a step pulse is on the output
    a_in = 1'b1;
    repeat (LAT - 1) tick();
    @(posedge clk);
    cyc++;
    #2;
    check("step_before_rst", step, 1'b1);
    check("dir_before_rst", dir, 1'b1);
    check("ready_before_rst", ready, 1'b1);
    if (sb.size() > 0) void'(sb.pop_front());
    rst = 1'b1;
    #1;
    check("mid_rst_step", step, 1'b0);
    check("mid_rst_dir", dir, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_sticky", err_sticky, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    @(negedge clk);
    a_in = 1'b1; b_in = 1'b1;
    repeat (3) tick();
    release_and_check_ready();
    repeat (10) tick();

    enable = 1'b0;
    for (int i = 0; i < 6; i++) apply(tbl2[i]);
    enable = 1'b1;
    repeat (10) tick();
    check("sticky_after_disabled", err_sticky, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
